// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one outstanding imem request at a time, result held for decode
// over valid/ready. Supports flush, misalign/access/timeout faults and a retired-fetch count.
module ysyx_25020047_ifu #(
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       ipc_q, ipc_d;
   logic              flt_q, flt_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              kill_q, kill_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              killed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         inst_q  <= '0;
         ipc_q   <= '0;
         flt_q   <= 1'b0;
         cnt_q   <= '0;
         kill_q  <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         flt_q   <= flt_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      flt_d   = flt_q;
      cnt_d   = cnt_q;
      kill_d  = kill_q;
      to_d    = to_q;
      // A flush in the completing cycle of WAIT kills that result too.
      killed  = kill_q | flush;
      unique case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (pc_valid) begin
               addr_d = pc_in;
               ipc_d  = pc_in;
               if (pc_in[1:0] != 2'b00) begin
                  inst_d  = '0;
                  flt_d   = 1'b1;
                  state_d = HOLD;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            // Request is never withdrawn; a flush only marks the result for discard.
            if (flush) kill_d = 1'b1;
            if (imem_req_ready) begin
               state_d = WAIT;
               to_d    = '0;
            end
         end
         WAIT: begin
            to_d = to_q + 1'b1;
            if (imem_rsp_valid || to_q == TO_W'(TIMEOUT - 1)) begin
               if (killed) begin
                  kill_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  inst_d  = imem_rsp_valid ? imem_rsp_data : 32'h0;
                  flt_d   = imem_rsp_valid ? imem_rsp_err : 1'b1;
                  state_d = HOLD;
               end
            end else if (flush) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               state_d = IDLE;
            end else if (inst_ready) begin
               cnt_d   = cnt_q + 32'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pc_ready       = (state_q == IDLE);
   assign imem_req_valid = (state_q == REQ);
   assign inst_valid     = (state_q == HOLD);
   assign imem_addr      = addr_q;
   assign inst           = inst_q;
   assign inst_pc        = ipc_q;
   assign inst_fault     = flt_q;
   assign fetch_cnt      = cnt_q;

endmodule
